sd_block_responder: RTL and testbench

- Target side of the save-state block handshake (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Serves 512-byte sector reads and writes against a synchronous byte-wide backing store (BRAM or SDRAM-side port), acting as an on-FPGA RAM disk for save slots.
- Answers the existing state-save sequencer directly: one request per sector, sd_ack framing each transfer.

---
 rtl/sd_block_responder.sv | 126 ++++++++++++
 tb/tb_sd_block_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_responder.sv
// Save-state block target: serves 512-byte sector reads/writes from a byte-wide backing store.
// Optional write-protect input enabled by defining SD_BLOCK_WP_EN.
module sd_block_responder #(
    parameter int LBA_W    = 8,
    parameter int IDLE_GAP = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [31:0]        sd_lba,
    input  logic               sd_rd,
    input  logic               sd_wr,
    output logic               sd_ack,
    output logic [8:0]         sd_buff_addr,
    output logic [7:0]         sd_buff_dout,
    output logic               sd_buff_wr,
    input  logic [7:0]         sd_buff_din,
    output logic [LBA_W+8:0]   store_addr,
    output logic               store_we,
    output logic [7:0]         store_wdata,
    input  logic [7:0]         store_rdata,
`ifdef SD_BLOCK_WP_EN
    input  logic               wp,
`endif
    output logic               err
);

    typedef enum logic [1:0] {IDLE, RD_XFER, WR_XFER, DONE} state_t;

    state_t           state, state_nx;
    logic [LBA_W-1:0] lba;
    logic             oor;
    logic             wp_l;
    logic             wp_in;
    logic [9:0]       ofs;
    logic [3:0]       gap;
    logic             rd_pend, wr_pend;
    logic [8:0]       pend_ofs;
    logic [8:0]       buff_addr;
    logic             err_q;
    logic             xfer, issue, accept;

`ifdef SD_BLOCK_WP_EN
    assign wp_in = wp;
`else
    assign wp_in = 1'b0;
`endif

    assign xfer   = (state == RD_XFER) || (state == WR_XFER);
    // ofs[9] marks that all 512 offsets were issued; no wrap into a second sector
    assign issue  = xfer && !ofs[9];
    assign accept = (state == IDLE) && (sd_rd || sd_wr);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (sd_rd)      state_nx = RD_XFER;
                else if (sd_wr) state_nx = WR_XFER;
            end
            RD_XFER, WR_XFER: if (ofs[9]) state_nx = DONE;
            DONE:             if (gap == 4'(IDLE_GAP - 1)) state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lba       <= '0;
            oor       <= 1'b0;
            wp_l      <= 1'b0;
            ofs       <= '0;
            gap       <= '0;
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            pend_ofs  <= '0;
            buff_addr <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_pend <= issue && (state == RD_XFER);
            wr_pend <= issue && (state == WR_XFER);
            if (issue) pend_ofs <= ofs[8:0];
            err_q <= xfer && ofs[9] && (oor || ((state == WR_XFER) && wp_l));
            case (state)
                IDLE: if (accept) begin
                    lba  <= sd_lba[LBA_W-1:0];
                    oor  <= |sd_lba[31:LBA_W];
                    wp_l <= wp_in && !sd_rd;
                    ofs  <= '0;
                    if (!sd_rd) buff_addr <= '0;
                end
                RD_XFER: begin
                    gap <= '0;
                    if (issue) begin
                        ofs       <= ofs + 10'd1;
                        buff_addr <= ofs[8:0];
                    end
                end
                WR_XFER: begin
                    gap <= '0;
                    if (issue) begin
                        ofs <= ofs + 10'd1;
                        // requester address leads the store by a cycle and parks at 511
                        if (ofs[8:0] != 9'd511) buff_addr <= ofs[8:0] + 9'd1;
                    end
                end
                DONE:    gap <= gap + 4'd1;
                default: ;
            endcase
        end
    end

    assign sd_ack       = xfer;
    assign sd_buff_addr = buff_addr;
    assign sd_buff_wr   = rd_pend;
    assign sd_buff_dout = (rd_pend && !oor) ? store_rdata : 8'h00;
    assign store_addr   = {lba, (state == RD_XFER) ? ofs[8:0] : pend_ofs};
    assign store_we     = wr_pend && !oor && !wp_l;
    assign store_wdata  = wr_pend ? sd_buff_din : 8'h00;
    assign err          = err_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder: store/buffer models plus a sector-level reference.
module tb_sd_block_responder;
    localparam int LBA_W    = 8;
    localparam int IDLE_GAP = 2;
    localparam int MEMSZ    = 1 << (LBA_W + 9);

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      sd_lba;
    logic             sd_rd, sd_wr;
    logic             sd_ack;
    logic [8:0]       sd_buff_addr;
    logic [7:0]       sd_buff_dout;
    logic             sd_buff_wr;
    logic [7:0]       sd_buff_din;
    logic [LBA_W+8:0] store_addr;
    logic             store_we;
    logic [7:0]       store_wdata;
    logic [7:0]       store_rdata;
    logic             err;
`ifdef SD_BLOCK_WP_EN
    logic             wp;
`endif

    sd_block_responder #(.LBA_W(LBA_W), .IDLE_GAP(IDLE_GAP)) dut (
        .clk_sys(clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .store_addr(store_addr),
        .store_we(store_we), .store_wdata(store_wdata), .store_rdata(store_rdata),
`ifdef SD_BLOCK_WP_EN
        .wp(wp),
`endif
        .err(err));

    always #5 clk = ~clk;

    logic [7:0]  mem[MEMSZ];
    logic [7:0]  ref_mem[MEMSZ];
    logic [7:0]  src[512];
    logic [7:0]  rbuf[512];
    logic [7:0]  exp_buf[512];
    logic        init_req;
    logic [31:0] cur_lba;

    // backing store: 1-cycle read latency, synchronous write
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] <= ref_mem[i];
        end else if (store_we) begin
            mem[store_addr] <= store_wdata;
        end
        store_rdata <= mem[store_addr];
    end

    // requester buffer: data follows the address by one cycle
    always @(posedge clk) sd_buff_din <= src[sd_buff_addr];

    int ack_tot = 0, str_tot = 0, we_tot = 0, err_tot = 0, bad_tot = 0;
    int s_idx = 0, w_idx = 0;

    always @(negedge clk) begin
        if (sd_ack) ack_tot++;
        if (err) err_tot++;
        if (sd_buff_wr) begin
            rbuf[sd_buff_addr] = sd_buff_dout;
            if (int'(sd_buff_addr) != s_idx) bad_tot++;
            s_idx++;
            str_tot++;
        end
        if (store_we) begin
            if (store_addr != {cur_lba[LBA_W-1:0], 9'(w_idx)} || store_wdata != src[w_idx % 512]) bad_tot++;
            w_idx++;
            we_tot++;
        end
        if (!sd_ack) begin
            s_idx = 0;
            w_idx = 0;
        end
    end

    int compared = 0, mismatched = 0;
    int s_ack, s_str, s_we, s_err, s_bad;

    task automatic chk(input string tag, input int got, input int expv);
        compared++;
        assert (got === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic snap();
        s_ack = ack_tot; s_str = str_tot; s_we = we_tot; s_err = err_tot; s_bad = bad_tot;
    endtask

    // sector-level reference: reads see store or zeros, in-range unprotected writes land
    task automatic model(input bit rd, input logic [31:0] lba, input bit wpv,
                         output bit is_rd, output bit bad);
        bit oor;
        oor   = lba >= 32'(1 << LBA_W);
        is_rd = rd;
        bad   = oor || (!rd && wpv);
        for (int i = 0; i < 512; i++) begin
            if (rd) exp_buf[i] = oor ? 8'h00 : ref_mem[int'(lba[LBA_W-1:0]) * 512 + i];
            else if (!bad) ref_mem[int'(lba[LBA_W-1:0]) * 512 + i] = src[i];
        end
    endtask

    task automatic start_req(input bit rd, input bit wr, input logic [31:0] lba,
                             input bit wpv, output int lat);
        cur_lba = lba;
        sd_lba  = lba;
        sd_rd   = rd;
        sd_wr   = wr;
`ifdef SD_BLOCK_WP_EN
        wp = wpv;
`else
        if (wpv) $display("note: wp ignored in this build");
`endif
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!sd_ack && lat < 40);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        if (!sd_ack) chk("ack_rise_timeout", int'(sd_ack), 1);
    endtask

    task automatic wait_fall();
        int n = 0;
        while (sd_ack && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        if (sd_ack) chk("ack_fall_timeout", int'(sd_ack), 0);
    endtask

    task automatic check_data(input bit is_rd, input logic [31:0] lba);
        int nbad = 0;
        for (int i = 0; i < 512; i++) begin
            if (is_rd) begin
                if (rbuf[i] !== exp_buf[i]) nbad++;
            end else if (lba < 32'(1 << LBA_W)) begin
                if (mem[int'(lba[LBA_W-1:0]) * 512 + i] !== ref_mem[int'(lba[LBA_W-1:0]) * 512 + i]) nbad++;
            end
        end
        chk(is_rd ? "read_data" : "store_data", nbad, 0);
    endtask

    task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba, input bit wpv);
        bit is_rd, bad;
        int lat;
        snap();
        model(rd, lba, wpv, is_rd, bad);
        start_req(rd, wr, lba, wpv, lat);
        chk("ack_latency", lat, 1);
        wait_fall();
        repeat (IDLE_GAP + 2) @(posedge clk);
        #1;
        chk("ack_len", ack_tot - s_ack, 513);
        chk("strobes", str_tot - s_str, is_rd ? 512 : 0);
        chk("store_we", we_tot - s_we, (!is_rd && !bad) ? 512 : 0);
        chk("order", bad_tot - s_bad, 0);
        chk("err", err_tot - s_err, int'(bad));
        check_data(is_rd, lba);
    endtask

    initial begin
        bit is_rd, bad;
        int lat, e0, n, r;
        logic [31:0] lba;

        reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0; init_req = 1'b1;
`ifdef SD_BLOCK_WP_EN
        wp = 1'b0;
`endif
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 512; i++) ref_mem[3 * 512 + i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 512; i++) src[i] = 8'h00;
        @(posedge clk); #1;
        init_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_ack", int'(sd_ack), 0);
        chk("rst_buff_addr", int'(sd_buff_addr), 0);
        chk("rst_buff_dout", int'(sd_buff_dout), 0);
        chk("rst_buff_wr", int'(sd_buff_wr), 0);
        chk("rst_store_addr", int'(store_addr), 0);
        chk("rst_store_we", int'(store_we), 0);
        chk("rst_store_wdata", int'(store_wdata), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        xfer(1'b1, 1'b0, 32'd3, 1'b0);
        for (int i = 0; i < 512; i++) src[i] = ~8'(i);
        xfer(1'b0, 1'b1, 32'd7, 1'b0);
        chk("buff_addr_hold", int'(sd_buff_addr), 511);
        xfer(1'b1, 1'b0, 32'd7, 1'b0);
        xfer(1'b1, 1'b0, 32'd256, 1'b0);
        for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
        xfer(1'b0, 1'b1, 32'h10000, 1'b0);
        xfer(1'b1, 1'b1, 32'd9, 1'b0);

        for (int t = 0; t < 8; t++) begin
            r   = int'($urandom_range(0, 2));
            lba = ($urandom_range(0, 4) == 0) ? (32'($urandom) | 32'h100) : 32'($urandom_range(0, 255));
            for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
            xfer(r != 1, r != 0, lba, 1'b0);
        end

        // sequencer-style burst: re-request as soon as sd_ack falls
        e0 = err_tot;
        for (int j = 0; j < 64; j++) begin
            snap();
            model(1'b1, 32'h40 + 32'(j), 1'b0, is_rd, bad);
            start_req(1'b1, 1'b0, 32'h40 + 32'(j), 1'b0, lat);
            if (j > 0) chk("burst_gap", lat, IDLE_GAP + 1);
            wait_fall();
            chk("burst_strobes", str_tot - s_str, 512);
            check_data(1'b1, 32'h40 + 32'(j));
        end
        repeat (IDLE_GAP + 2) @(posedge clk);
        #1;
        chk("burst_err", err_tot - e0, 0);

        // reset while writing lba 5: bytes 0..199 land, the rest stay untouched
        for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
        snap();
        start_req(1'b0, 1'b1, 32'd5, 1'b0, lat);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(store_we && store_addr[8:0] == 9'd199) && n < 700);
        chk("reset_point_found", int'(store_we && store_addr[8:0] == 9'd199), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_async_ack", int'(sd_ack), 0);
        chk("rst_async_we", int'(store_we), 0);
        chk("rst_async_buff_wr", int'(sd_buff_wr), 0);
        for (int i = 0; i < 200; i++) ref_mem[5 * 512 + i] = src[i];
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_data(1'b0, 32'd5);
        chk("rst_no_err", err_tot - s_err, 0);
        xfer(1'b1, 1'b0, 32'd5, 1'b0);

`ifdef SD_BLOCK_WP_EN
        for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
        xfer(1'b0, 1'b1, 32'd2, 1'b1);
        xfer(1'b1, 1'b0, 32'd2, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
